twos_to_sign_mag: RTL and testbench

TWOS_TO_SIGN_MAG -- requirements
Module: twos_to_sign_mag

---
 rtl/twos_to_sign_mag.sv | 130 +++++++++++++
 tb/tb_twos_to_sign_mag.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_to_sign_mag.sv
// Sequential two's-complement to sign/magnitude converter, CHUNK bits per clock.
// Optional saturation of the most negative input: define TWOS_SM_SATURATE_EN.
module twos_to_sign_mag #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [N-1:0] out_mag,
  output logic         out_ovf
);

  localparam int SLICES = N / CHUNK;
  localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

`ifdef TWOS_SM_SATURATE_EN
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [IW-1:0]  idx_r;
  logic           carry_r;
  logic [N-1:0]   data_r;
  logic           sign_r;
  logic [N-1:0]   mag_r;
  logic           ovf_r;
  logic           in_ready_r;
  logic           out_valid_r;

  int             base_s;
  logic [CHUNK:0] slice_sum_s;
  logic [N-1:0]   mag_next_s;
  logic           last_slice_s;

  // Conditional-negate adder for the current slice and the merged magnitude word
  always_comb begin
    base_s       = int'(idx_r) * CHUNK;
    slice_sum_s  = {1'b0, data_r[base_s +: CHUNK] ^ {CHUNK{sign_r}}}
                 + {{CHUNK{1'b0}}, carry_r};
    mag_next_s   = mag_r;
    mag_next_s[base_s +: CHUNK] = slice_sum_s[CHUNK-1:0];
    last_slice_s = (idx_r == IW'(SLICES - 1));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid)     state_s = CONVERT; else state_s = IDLE;
      CONVERT: if (last_slice_s) state_s = DONE;    else state_s = CONVERT;
      DONE:    if (out_ready)    state_s = IDLE;    else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Capture, per-slice accumulation, and optional saturation on the last slice
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= {IW{1'b0}};
      carry_r <= 1'b0;
      data_r  <= {N{1'b0}};
      sign_r  <= 1'b0;
      mag_r   <= {N{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r  <= in_data;
            sign_r  <= in_data[N-1];
            carry_r <= in_data[N-1];
            idx_r   <= {IW{1'b0}};
            mag_r   <= {N{1'b0}};
            ovf_r   <= 1'b0;
          end
        end
        CONVERT: begin
          carry_r <= slice_sum_s[CHUNK];
          idx_r   <= idx_r + IW'(1);
`ifdef TWOS_SM_SATURATE_EN
          if (last_slice_s && (data_r == MIN_NEG)) begin
            mag_r <= MAX_POS;
            ovf_r <= 1'b1;
          end else begin
            mag_r <= mag_next_s;
          end
`else
          mag_r   <= mag_next_s;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sign  = sign_r;
  assign out_mag   = mag_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_twos_to_sign_mag.sv
// Self-checking bench for twos_to_sign_mag: directed cases, backpressure,
// mid-conversion reset and a randomized stream against an arithmetic model.
module tb_twos_to_sign_mag;

  localparam int N      = 32;
  localparam int CHUNK  = 8;
  localparam int SLICES = N / CHUNK;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [N-1:0] out_mag;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  twos_to_sign_mag #(.N(N), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: sign and absolute value from signed arithmetic
  function automatic void ref_model(input logic [N-1:0] w, output logic s,
                                    output logic [N-1:0] m, output logic o);
    longint v, a;
    v = longint'($signed(w));
    s = (v < 64'sd0);
    a = s ? -v : v;
    m = a[N-1:0];
    o = 1'b0;
`ifdef TWOS_SM_SATURATE_EN
    if (a == (64'sd1 <<< (N-1))) begin
      m = a[N-1:0] - 32'd1;
      o = 1'b1;
    end
`endif
  endfunction

  // Drives one word and collects the result; comparisons are left to the callers
  task automatic do_xfer(input logic [N-1:0] w, input int stall, output int lat,
                         output int acc_cyc, output logic s, output logic [N-1:0] m,
                         output logic o, output bit tmo);
    int k;
    tmo = 1'b0;
    out_ready = (stall == 0);
    in_valid = 1'b1;
    in_data = w;
    k = 0;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!in_ready) tmo = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_data = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      in_data = $urandom;
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!out_valid) tmo = 1'b1;
    s = out_sign; m = out_mag; o = out_ovf;
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_sign, out_mag, out_ovf} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset rdy/vld/sign/mag/ovf got %b %b %b %h %b exp 1 0 0 0 0",
               in_ready, out_valid, out_sign, out_mag, out_ovf);
    end
  endtask

  task automatic test_directed;
    logic [N-1:0] words [5] = '{32'h0000000A, 32'hFFFFFF92, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    logic         exp_s [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef TWOS_SM_SATURATE_EN
    logic [N-1:0] exp_m [5] = '{32'h0000000A, 32'h0000006E, 32'h1, 32'h7FFFFFFF, 32'h0};
    logic         exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    logic [N-1:0] exp_m [5] = '{32'h0000000A, 32'h0000006E, 32'h1, 32'h80000000, 32'h0};
    logic         exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    int lat, acc;
    logic s, o;
    logic [N-1:0] m;
    bit tmo;
    for (int i = 0; i < 5; i++) begin
      do_xfer(words[i], 0, lat, acc, s, m, o, tmo);
      checks++;
      if (tmo !== 1'b0) begin errors++; $display("FAIL dir_timeout word %h got timeout exp none", words[i]); end
      checks++;
      if (lat !== SLICES) begin errors++; $display("FAIL dir_latency word %h got %0d exp %0d", words[i], lat, SLICES); end
      checks++;
      if ({s, m, o} !== {exp_s[i], exp_m[i], exp_o[i]}) begin
        errors++;
        $display("FAIL dir_result word %h got s=%b m=%h o=%b exp s=%b m=%h o=%b",
                 words[i], s, m, o, exp_s[i], exp_m[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int k;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hFFFFFF92;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_done got out_valid=%b exp 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_sign, out_mag, out_ovf} !== {1'b1, 1'b0, 1'b1, 32'h6E, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b s=%b m=%h o=%b exp 1 0 1 0000006e 0",
                 i, out_valid, in_ready, out_sign, out_mag, out_ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_drain got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int lat, acc;
    logic s, o;
    logic [N-1:0] m;
    bit tmo, seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hFFFF1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_sign, out_mag, out_ovf} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_state got rdy=%b vld=%b s=%b m=%h o=%b exp 1 0 0 0 0",
               in_ready, out_valid, out_sign, out_mag, out_ovf);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_ghost got out_valid seen=1 exp 0"); end
    do_xfer(32'h00000023, 0, lat, acc, s, m, o, tmo);
    checks++;
    if ({tmo, s, m, o} !== {1'b0, 1'b0, 32'h23, 1'b0}) begin
      errors++; $display("FAIL midrst_fresh got tmo=%b s=%b m=%h o=%b exp 0 0 00000023 0", tmo, s, m, o);
    end
  endtask

  task automatic test_back_to_back;
    int lat, acc, prev_acc, prev_stall, stall, sel;
    logic s, o, es, eo;
    logic [N-1:0] m, em, w;
    bit tmo;
    prev_acc = -1;
    prev_stall = 1;
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       w = 32'h0;
        1:       w = 32'h80000000;
        2:       w = 32'hFFFFFFFF;
        3:       w = 32'h7FFFFFFF;
        default: w = $urandom;
      endcase
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ref_model(w, es, em, eo);
      do_xfer(w, stall, lat, acc, s, m, o, tmo);
      checks++;
      if (tmo !== 1'b0) begin errors++; $display("FAIL rnd_timeout #%0d word %h got timeout exp none", i, w); end
      checks++;
      if (lat !== SLICES) begin errors++; $display("FAIL rnd_latency #%0d got %0d exp %0d", i, lat, SLICES); end
      checks++;
      if ({s, m, o} !== {es, em, eo}) begin
        errors++;
        $display("FAIL rnd_result #%0d word %h got s=%b m=%h o=%b exp s=%b m=%h o=%b",
                 i, w, s, m, o, es, em, eo);
      end
      if (prev_acc >= 0 && prev_stall == 0) begin
        checks++;
        if (acc - prev_acc !== SLICES + 2) begin
          errors++; $display("FAIL rnd_spacing #%0d got %0d exp %0d", i, acc - prev_acc, SLICES + 2);
        end
      end
      prev_acc = acc;
      prev_stall = stall;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
